pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 16-bit 5-stage pipeline.
- Detects load-use hazards, taken branches, multi-cycle multiply occupancy and memory wait states.
- Drives the Freze and synchronous flush (rest) inputs of the IF/ID, ID/EX and EX/MEM pipeline registers, plus PC hold.
- Also keeps a saturating stall counter and a sticky memory-timeout flag.

Parameters:
- RIDX_W, 3, register-index width compared for hazards (8 GPRs).
- MUL_CYCLES, 4, cycles a multiply occupies EX; legal range is 2 or more.
- MEM_TIMEOUT, 255, consecutive memory-wait cycles that set mem_error; range 1..65535.

Ports:
- clk  in  1  system clock.
- rest  in  1  asynchronous active-low reset.
- id_rs  in  RIDX_W  source-1 index of instruction in ID.
- id_rt  in  RIDX_W  source-2 index of instruction in ID.
- id_uses_rs  in  1  ID instruction reads id_rs.
- id_uses_rt  in  1  ID instruction reads id_rt.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  RIDX_W  destination index of instruction in EX.
- ex_mul_start  in  1  instruction in EX is a multiply.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_req  in  1  MEM stage has an access outstanding.
- mem_ready  in  1  memory completes the access this cycle.
- pc_freeze  out  1  hold PC.
- ifid_freeze  out  1  Freze for IF/ID.
- ifid_flush  out  1  sync clear for IF/ID.
- idex_freeze  out  1  Freze for ID/EX.
- idex_flush  out  1  sync clear (rest) for ID/EX.
- exmem_freeze  out  1  Freze for EX/MEM.
- mul_done  out  1  one-cycle pulse, multiply result valid.
- mem_error  out  1  sticky memory timeout flag.
- stall_count  out  16  saturating count of cycles with pc_freeze=1.

Behaviour:
- State: FSM {RUN, MUL_BUSY}, mul_cnt (width clog2(MUL_CYCLES)), mem_wait_cnt (16-bit), mem_error, stall_count.
- Reset (rest=0, asynchronous):
  - State goes to RUN; all counters and mem_error go to 0.
  - While rest=0, all freeze outputs are 0, ifid_flush=idex_flush=1, mul_done=0.
- All stall/flush outputs are combinational from inputs and state; they take effect at the next clk edge (zero added latency).
- mem_stall = mem_req & ~mem_ready.
- load_use = ex_mem_read & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)). Index 0 is not special.
- Priority, highest first:
  1. mem_stall: pc, ifid, idex and exmem freeze = 1; no flush.
  2. Multiply freeze (mul_freeze, defined below): all four freezes = 1.
  3. ex_branch_taken: ifid_flush=1, idex_flush=1; no freeze.
  4. load_use: pc_freeze=1, ifid_freeze=1, idex_flush=1 (bubble); idex_freeze=0, exmem_freeze=0.
  - Freeze and flush are never asserted together on the same register.
- RUN state:
  - ex_mul_start=1 sets mul_freeze=1, loads mul_cnt <= MUL_CYCLES-2 and moves to MUL_BUSY.
  - This happens even if mem_stall=1 the same cycle.
- MUL_BUSY state:
  - ex_mul_start is ignored.
  - If mul_cnt != 0: mul_freeze=1 and mul_cnt decrements every cycle, independent of mem_stall.
  - If mul_cnt == 0 and mem_stall=0: mul_freeze=0, mul_done=1, next state RUN.
  - If mul_cnt == 0 and mem_stall=1: remain in MUL_BUSY, mul_done=0 (the done cycle is deferred).
  - Net effect: the multiply sits in EX for exactly MUL_CYCLES cycles with MUL_CYCLES-1 freeze cycles when no memory stall intervenes.
  - In the done cycle, branch and load_use rules apply normally.
- mem_wait_cnt:
  - Increments each cycle with mem_stall=1, saturating at 0xFFFF; clears when mem_stall=0.
  - mem_error is set on the edge where mem_wait_cnt reaches MEM_TIMEOUT; it stays set until reset.
  - The stall continues regardless of mem_error.
- stall_count: increments on every edge where pc_freeze=1; saturates at 0xFFFF (no wrap).

Test Plan:
- Reset: assert rest=0 mid-MUL_BUSY with mul_cnt=1 -> state RUN immediately, mul_done=0, idex_flush=1, stall_count=0, mem_error=0; release -> all outputs 0 with idle inputs.
- Load-use: ex_mem_read=1, ex_rd=3, id_rs=3, id_uses_rs=1 for one cycle -> pc_freeze=ifid_freeze=idex_flush=1, idex_freeze=exmem_freeze=0; id_uses_rs=0 with the same indices -> no stall.
- Branch vs load-use: ex_branch_taken=1 concurrent with a load_use match -> ifid_flush=idex_flush=1, pc_freeze=0, ifid_freeze=0.
- Multiply, MUL_CYCLES=4: ex_mul_start pulse held 4 cycles -> freezes high cycles 0-2, low with mul_done=1 in cycle 3, stall_count=3; MUL_CYCLES=2 -> 1 freeze cycle, then mul_done.
- Mem during multiply: mem_stall high over cycles 2-5 of a MUL_CYCLES=4 multiply -> freezes high through cycle 5, mul_done pulses in cycle 6 only, exactly once.
- Timeout and saturation: MEM_TIMEOUT=5, mem_req=1, mem_ready=0 for 5 cycles -> mem_error=1 after the 5th edge and held after mem_ready=1; 70000 stall cycles -> stall_count=0xFFFF.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bus: pipeline status inputs and stall/flush controls.
// The pipeline side uses the master modport, the controller uses slave.
interface pipeline_hazard_controller_if #(
    parameter int RIDX_W = 3
);
    logic [RIDX_W-1:0] id_rs;
    logic [RIDX_W-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              ex_mem_read;
    logic [RIDX_W-1:0] ex_rd;
    logic              ex_mul_start;
    logic              ex_branch_taken;
    logic              mem_req;
    logic              mem_ready;

    logic              pc_freeze;
    logic              ifid_freeze;
    logic              ifid_flush;
    logic              idex_freeze;
    logic              idex_flush;
    logic              exmem_freeze;
    logic              mul_done;
    logic              mem_error;
    logic [15:0]       stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
               ex_mul_start, ex_branch_taken, mem_req, mem_ready,
        input  pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_flush,
               exmem_freeze, mul_done, mem_error, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
               ex_mul_start, ex_branch_taken, mem_req, mem_ready,
        output pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_flush,
               exmem_freeze, mul_done, mem_error, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 16-bit 5-stage pipeline.
// Handles memory wait states, multi-cycle multiply occupancy of EX,
// taken branches and load-use hazards, in that priority order, and keeps
// a saturating stall counter plus a sticky memory-timeout flag.
module pipeline_hazard_controller #(
    parameter int RIDX_W      = 3,
    parameter int MUL_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rest,
    pipeline_hazard_controller_if.slave hz
);

    localparam int               MUL_CNT_W   = $clog2(MUL_CYCLES);
    localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(MUL_CYCLES - 2);
    localparam logic [15:0]      TIMEOUT_VAL = 16'(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [MUL_CNT_W-1:0]   mul_cnt;
    logic [MUL_CNT_W-1:0]   mul_cnt_next;
    logic                   mul_freeze;
    logic                   mul_done_raw;
    logic [15:0]            mem_wait_cnt;
    logic [15:0]            mem_wait_inc;
    logic                   mem_error_q;
    logic [15:0]            stall_count_q;

    logic [RIDX_W-1:0]      rs_idx;
    logic [RIDX_W-1:0]      rt_idx;
    logic [RIDX_W-1:0]      rd_idx;
    logic                   mem_stall;
    logic                   load_use;

    logic                   pc_freeze_c;
    logic                   ifid_freeze_c;
    logic                   ifid_flush_c;
    logic                   idex_freeze_c;
    logic                   idex_flush_c;
    logic                   exmem_freeze_c;

    assign rs_idx    = hz.id_rs;
    assign rt_idx    = hz.id_rt;
    assign rd_idx    = hz.ex_rd;
    assign mem_stall = hz.mem_req & ~hz.mem_ready;
    assign load_use  = hz.ex_mem_read &
                       ((hz.id_uses_rs & (rs_idx == rd_idx)) |
                        (hz.id_uses_rt & (rt_idx == rd_idx)));

    // Multiply sequencing: the countdown runs regardless of memory stalls,
    // only the final done cycle waits for the memory stall to clear.
    always_comb begin
        state_next   = state;
        mul_cnt_next = mul_cnt;
        mul_freeze   = 1'b0;
        mul_done_raw = 1'b0;
        case (state)
            RUN: begin
                if (hz.ex_mul_start) begin
                    mul_freeze   = 1'b1;
                    mul_cnt_next = MUL_LOAD;
                    state_next   = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (mul_cnt != '0) begin
                    mul_freeze   = 1'b1;
                    mul_cnt_next = mul_cnt - 1'b1;
                end else if (!mem_stall) begin
                    mul_done_raw = 1'b1;
                    state_next   = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Prioritised freeze/flush selection; reset forces both flushes.
    always_comb begin
        pc_freeze_c    = 1'b0;
        ifid_freeze_c  = 1'b0;
        ifid_flush_c   = 1'b0;
        idex_freeze_c  = 1'b0;
        idex_flush_c   = 1'b0;
        exmem_freeze_c = 1'b0;
        if (!rest) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
        end else if (mem_stall || mul_freeze) begin
            pc_freeze_c    = 1'b1;
            ifid_freeze_c  = 1'b1;
            idex_freeze_c  = 1'b1;
            exmem_freeze_c = 1'b1;
        end else if (hz.ex_branch_taken) begin
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
        end else if (load_use) begin
            pc_freeze_c   = 1'b1;
            ifid_freeze_c = 1'b1;
            idex_flush_c  = 1'b1;
        end
    end

    assign hz.pc_freeze    = pc_freeze_c;
    assign hz.ifid_freeze  = ifid_freeze_c;
    assign hz.ifid_flush   = ifid_flush_c;
    assign hz.idex_freeze  = idex_freeze_c;
    assign hz.idex_flush   = idex_flush_c;
    assign hz.exmem_freeze = exmem_freeze_c;
    assign hz.mul_done     = mul_done_raw & rest;
    assign hz.mem_error    = mem_error_q;
    assign hz.stall_count  = stall_count_q;

    // Multiply FSM state and countdown register.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state   <= RUN;
            mul_cnt <= '0;
        end else begin
            state   <= state_next;
            mul_cnt <= mul_cnt_next;
        end
    end

    assign mem_wait_inc = (mem_wait_cnt == 16'hFFFF) ? mem_wait_cnt : mem_wait_cnt + 16'd1;

    // Consecutive memory-wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            mem_wait_cnt <= '0;
            mem_error_q  <= 1'b0;
        end else if (mem_stall) begin
            mem_wait_cnt <= mem_wait_inc;
            if (mem_wait_inc == TIMEOUT_VAL) begin
                mem_error_q <= 1'b1;
            end
        end else begin
            mem_wait_cnt <= '0;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            stall_count_q <= '0;
        end else if (pc_freeze_c && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed, scoreboard-based bench for pipeline_hazard_controller.
// dut1 runs MUL_CYCLES=4 / MEM_TIMEOUT=5, dut2 runs MUL_CYCLES=2; both see
// the same inputs, each step names which instance its expectation is for.
module tb_pipeline_hazard_controller;

    // Flag order: pc_freeze, ifid_freeze, ifid_flush, idex_freeze,
    //             idex_flush, exmem_freeze, mul_done
    localparam logic [6:0] F_NONE = 7'b000_0000;
    localparam logic [6:0] F_FRZ  = 7'b110_1010;
    localparam logic [6:0] F_LU   = 7'b110_0100;
    localparam logic [6:0] F_BR   = 7'b001_0100;
    localparam logic [6:0] F_DONE = 7'b000_0001;
    localparam logic [6:0] F_BRDN = 7'b001_0101;

    typedef struct packed {
        logic [2:0] id_rs;
        logic [2:0] id_rt;
        logic       id_uses_rs;
        logic       id_uses_rt;
        logic       ex_mem_read;
        logic [2:0] ex_rd;
        logic       ex_mul_start;
        logic       ex_branch_taken;
        logic       mem_req;
        logic       mem_ready;
    } stim_t;

    logic  clk;
    logic  rest;
    stim_t s;

    int checks_total;
    int checks_passed;
    int sc_model;
    logic err_model;

    logic [6:0]  flag_q[$];
    logic [15:0] sc_q[$];
    logic        err_q[$];
    logic        dut_q[$];
    string       tag_q[$];

    pipeline_hazard_controller_if #(.RIDX_W(3)) hz1 ();
    pipeline_hazard_controller_if #(.RIDX_W(3)) hz2 ();

    pipeline_hazard_controller #(
        .RIDX_W(3), .MUL_CYCLES(4), .MEM_TIMEOUT(5)
    ) u_dut1 (
        .clk (clk),
        .rest(rest),
        .hz  (hz1)
    );

    pipeline_hazard_controller #(
        .RIDX_W(3), .MUL_CYCLES(2), .MEM_TIMEOUT(255)
    ) u_dut2 (
        .clk (clk),
        .rest(rest),
        .hz  (hz2)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_inputs();
        hz1.id_rs = s.id_rs;            hz2.id_rs = s.id_rs;
        hz1.id_rt = s.id_rt;            hz2.id_rt = s.id_rt;
        hz1.id_uses_rs = s.id_uses_rs;  hz2.id_uses_rs = s.id_uses_rs;
        hz1.id_uses_rt = s.id_uses_rt;  hz2.id_uses_rt = s.id_uses_rt;
        hz1.ex_mem_read = s.ex_mem_read; hz2.ex_mem_read = s.ex_mem_read;
        hz1.ex_rd = s.ex_rd;            hz2.ex_rd = s.ex_rd;
        hz1.ex_mul_start = s.ex_mul_start; hz2.ex_mul_start = s.ex_mul_start;
        hz1.ex_branch_taken = s.ex_branch_taken; hz2.ex_branch_taken = s.ex_branch_taken;
        hz1.mem_req = s.mem_req;        hz2.mem_req = s.mem_req;
        hz1.mem_ready = s.mem_ready;    hz2.mem_ready = s.mem_ready;
    endtask

    task automatic push_expect(input logic [6:0] flags, input logic on_dut2, input string tag);
        flag_q.push_back(flags);
        sc_q.push_back(16'(sc_model));
        err_q.push_back(err_model);
        dut_q.push_back(on_dut2);
        tag_q.push_back(tag);
    endtask

    task automatic check_output();
        logic [6:0]  exp_flags;
        logic [15:0] exp_sc;
        logic        exp_err;
        logic        on_dut2;
        string       tag;
        logic [6:0]  obs_flags;
        exp_flags = flag_q.pop_front();
        exp_sc    = sc_q.pop_front();
        exp_err   = err_q.pop_front();
        on_dut2   = dut_q.pop_front();
        tag       = tag_q.pop_front();
        if (on_dut2)
            obs_flags = {hz2.pc_freeze, hz2.ifid_freeze, hz2.ifid_flush, hz2.idex_freeze,
                         hz2.idex_flush, hz2.exmem_freeze, hz2.mul_done};
        else
            obs_flags = {hz1.pc_freeze, hz1.ifid_freeze, hz1.ifid_flush, hz1.idex_freeze,
                         hz1.idex_flush, hz1.exmem_freeze, hz1.mul_done};
        checks_total++;
        assert (obs_flags === exp_flags) checks_passed++;
        else $error("[TB] FAIL %s.flags observed=%b expected=%b", tag, obs_flags, exp_flags);
        if (!on_dut2) begin
            checks_total++;
            assert (hz1.stall_count === exp_sc) checks_passed++;
            else $error("[TB] FAIL %s.stall_count observed=%0d expected=%0d",
                        tag, hz1.stall_count, exp_sc);
            checks_total++;
            assert (hz1.mem_error === exp_err) checks_passed++;
            else $error("[TB] FAIL %s.mem_error observed=%b expected=%b",
                        tag, hz1.mem_error, exp_err);
        end
    endtask

    // One clock cycle: drive after the edge, record the expectation,
    // compare on the falling edge.
    task automatic apply_stimulus(input logic [6:0] flags, input logic on_dut2, input string tag);
        @(posedge clk);
        #1;
        drive_inputs();
        push_expect(flags, on_dut2, tag);
        if (!on_dut2 && flags[6] && sc_model < 65535) sc_model++;
        @(negedge clk);
        check_output();
    endtask

    task automatic check_reset(input string tag);
        sc_model  = 0;
        err_model = 1'b0;
        push_expect(F_BR, 1'b0, tag);
        #1;
        check_output();
    endtask

    // Directed sequence.
    initial begin
        checks_total  = 0;
        checks_passed = 0;
        sc_model      = 0;
        err_model     = 1'b0;
        s    = '0;
        rest = 1'b0;
        drive_inputs();
        @(posedge clk);
        @(posedge clk);
        check_reset("reset_hold");
        @(posedge clk);
        #1 rest = 1'b1;

        apply_stimulus(F_NONE, 1'b0, "idle");

        s.ex_mem_read = 1'b1; s.ex_rd = 3'd3; s.id_rs = 3'd3; s.id_uses_rs = 1'b1;
        apply_stimulus(F_LU, 1'b0, "load_use_rs");
        s.id_uses_rs = 1'b0;
        apply_stimulus(F_NONE, 1'b0, "load_use_unused");
        s.id_rs = 3'd2; s.id_uses_rs = 1'b1; s.id_rt = 3'd5; s.id_uses_rt = 1'b1; s.ex_rd = 3'd5;
        apply_stimulus(F_LU, 1'b0, "load_use_rt");
        s = '0; s.ex_mem_read = 1'b1; s.id_uses_rs = 1'b1;
        apply_stimulus(F_LU, 1'b0, "load_use_idx0");
        s.ex_mem_read = 1'b0;
        apply_stimulus(F_NONE, 1'b0, "no_load");
        s.ex_mem_read = 1'b1; s.ex_branch_taken = 1'b1;
        apply_stimulus(F_BR, 1'b0, "branch_over_lu");
        s.mem_req = 1'b1;
        apply_stimulus(F_FRZ, 1'b0, "mem_over_branch");
        s = '0; s.mem_req = 1'b1; s.mem_ready = 1'b1;
        apply_stimulus(F_NONE, 1'b0, "mem_ready");

        s = '0; s.ex_mul_start = 1'b1;
        apply_stimulus(F_FRZ, 1'b0, "mul4_c0");
        apply_stimulus(F_FRZ, 1'b0, "mul4_c1");
        apply_stimulus(F_FRZ, 1'b0, "mul4_c2");
        apply_stimulus(F_DONE, 1'b0, "mul4_done");
        s = '0;
        apply_stimulus(F_NONE, 1'b0, "mul4_after");

        s.ex_mul_start = 1'b1;
        apply_stimulus(F_FRZ, 1'b0, "mulbr_c0");
        s = '0;
        apply_stimulus(F_FRZ, 1'b0, "mulbr_c1");
        apply_stimulus(F_FRZ, 1'b0, "mulbr_c2");
        s.ex_branch_taken = 1'b1;
        apply_stimulus(F_BRDN, 1'b0, "mulbr_done");
        s = '0;
        apply_stimulus(F_NONE, 1'b0, "mulbr_after");

        s.ex_mul_start = 1'b1;
        apply_stimulus(F_FRZ, 1'b0, "mulmem_c0");
        s = '0;
        apply_stimulus(F_FRZ, 1'b0, "mulmem_c1");
        s.mem_req = 1'b1;
        for (int i = 2; i <= 5; i++) apply_stimulus(F_FRZ, 1'b0, $sformatf("mulmem_c%0d", i));
        s = '0;
        apply_stimulus(F_DONE, 1'b0, "mulmem_done");
        apply_stimulus(F_NONE, 1'b0, "mulmem_once");

        s.ex_mul_start = 1'b1; s.mem_req = 1'b1;
        apply_stimulus(F_FRZ, 1'b0, "mulstartmem_c0");
        s = '0;
        apply_stimulus(F_FRZ, 1'b0, "mulstartmem_c1");
        apply_stimulus(F_FRZ, 1'b0, "mulstartmem_c2");
        apply_stimulus(F_DONE, 1'b0, "mulstartmem_done");
        apply_stimulus(F_NONE, 1'b0, "mulstartmem_after");

        s.mem_req = 1'b1;
        for (int i = 1; i <= 5; i++) apply_stimulus(F_FRZ, 1'b0, $sformatf("timeout_w%0d", i));
        err_model = 1'b1;
        s.mem_ready = 1'b1;
        apply_stimulus(F_NONE, 1'b0, "timeout_set");
        s = '0;
        apply_stimulus(F_NONE, 1'b0, "timeout_sticky");

        s.mem_req = 1'b1;
        @(posedge clk);
        #1 drive_inputs();
        repeat (69999) @(posedge clk);
        sc_model = (sc_model + 70000 > 65535) ? 65535 : sc_model + 70000;
        apply_stimulus(F_FRZ, 1'b0, "sat_stall");
        s.mem_ready = 1'b1;
        apply_stimulus(F_NONE, 1'b0, "sat_nowrap");

        s = '0; s.ex_mul_start = 1'b1;
        apply_stimulus(F_FRZ, 1'b0, "midrst_c0");
        s = '0;
        apply_stimulus(F_FRZ, 1'b0, "midrst_c1");
        @(posedge clk);
        #1;
        rest = 1'b0;
        drive_inputs();
        check_reset("reset_mid_mul");
        @(posedge clk);
        @(posedge clk);
        #1 rest = 1'b1;
        apply_stimulus(F_NONE, 1'b0, "post_reset_idle");

        s.ex_mul_start = 1'b1;
        apply_stimulus(F_FRZ, 1'b1, "mul2_c0");
        apply_stimulus(F_DONE, 1'b1, "mul2_done");
        s = '0;
        apply_stimulus(F_NONE, 1'b1, "mul2_after");
        s.ex_mul_start = 1'b1;
        apply_stimulus(F_FRZ, 1'b1, "mul2b_c0");
        s = '0;
        apply_stimulus(F_DONE, 1'b1, "mul2b_done");
        apply_stimulus(F_NONE, 1'b1, "mul2b_after");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
